// File: rtl/segment_transition_ctl.sv
// segment_transition_ctl
// Segment-swap controller for the modulation and STM timing paths. Holds the
// active read segment, applies software segment-change requests once their
// transition trigger fires, counts loop repetitions of the active segment and
// raises STOP when a finite run is exhausted. EXT mode instead advances around
// all segments in an endless ring.
module segment_transition_ctl #(
  parameter int NumSegment   = 2,
  parameter int SegWidth     = $clog2(NumSegment),
  parameter int RepWidth     = 16,
  parameter int SysTimeWidth = 56,
  parameter int NumGpio      = 4
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    UPDATE,
  input  logic [SegWidth-1:0]     REQ_SEGMENT,
  input  logic [RepWidth-1:0]     REQ_REP,
  input  logic [7:0]              TRANSITION_MODE,
  input  logic [63:0]             TRANSITION_VALUE,
  input  logic                    SYNC_IDX_ZERO,
  input  logic [SysTimeWidth-1:0] SYS_TIME,
  input  logic [NumGpio-1:0]      GPIO_IN,
  input  logic                    LOOP_END,
  output logic [SegWidth-1:0]     SEGMENT,
  output logic                    SWAP,
  output logic                    STOP,
  output logic                    BUSY,
  output logic                    ERR
);

  localparam int PinWidth = (NumGpio > 1) ? $clog2(NumGpio) : 1;

  // Segment bound with one spare bit so the compare works for any NumSegment.
  localparam logic [SegWidth:0]   SegLimit = (SegWidth+1)'(NumSegment);
  localparam logic [SegWidth-1:0] LastSeg  = SegWidth'(NumSegment - 1);

  // Internal compact encoding of the four legal transition modes.
  localparam logic [1:0] ModeSync = 2'd0;
  localparam logic [1:0] ModeTime = 2'd1;
  localparam logic [1:0] ModeGpio = 2'd2;
  localparam logic [1:0] ModeExt  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_COUNT   = 2'd2,
    ST_STOPPED = 2'd3
  } state_t;

  // Control state (reset)
  state_t                state_q, state_d;
  logic [SegWidth-1:0]   seg_q, seg_d;
  logic                  swap_q, swap_d;
  logic                  stop_q, stop_d;
  logic                  busy_q, busy_d;
  logic                  err_q, err_d;
  logic [RepWidth-1:0]   cnt_q, cnt_d;
  logic [SegWidth-1:0]   req_seg_q, req_seg_d;
  logic [RepWidth-1:0]   rep_q, rep_d;
  logic [1:0]            mode_q, mode_d;
  logic [NumGpio-1:0]    gpio_prev_q;

  // Trigger operands (only meaningful once a request has been loaded)
  logic [SysTimeWidth-1:0] target_q;
  logic [PinWidth-1:0]     pin_q;
  logic                    load_data;

  // Request decode and trigger evaluation
  logic                  req_valid;
  logic                  req_inf;
  logic                  mode_ok;
  logic [1:0]            req_mode;
  logic [NumGpio-1:0]    gpio_rise;
  logic                  trig;
  logic [SegWidth-1:0]   seg_adv;

  // Only the low bits of TRANSITION_VALUE carry a target time or a pin index.
  logic unused_value_bits;
  assign unused_value_bits = ^TRANSITION_VALUE;

  // Validate the incoming request and map the mode byte to the internal code.
  always_comb begin
    mode_ok  = 1'b1;
    req_mode = ModeSync;
    case (TRANSITION_MODE)
      8'h00:   req_mode = ModeSync;
      8'h01:   req_mode = ModeTime;
      8'h02:   req_mode = ModeGpio;
      8'hF0:   req_mode = ModeExt;
      default: mode_ok  = 1'b0;
    endcase
    req_valid = mode_ok && ({1'b0, REQ_SEGMENT} < SegLimit);
    req_inf   = &REQ_REP;
  end

  // Evaluate the pending request's trigger condition for this cycle.
  always_comb begin
    gpio_rise = GPIO_IN & ~gpio_prev_q;
    trig      = 1'b0;
    case (mode_q)
      ModeTime: trig = (SYS_TIME >= target_q);
      ModeGpio: trig = gpio_rise[pin_q];
      default:  trig = SYNC_IDX_ZERO;
    endcase
    // Explicit wrap so non-power-of-two segment counts ring correctly.
    seg_adv = (seg_q == LastSeg) ? '0 : seg_q + SegWidth'(1);
  end

  // Next-state logic: a request always takes priority over triggers and loop ends.
  always_comb begin
    state_d   = state_q;
    seg_d     = seg_q;
    swap_d    = 1'b0;
    stop_d    = stop_q;
    busy_d    = busy_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    req_seg_d = req_seg_q;
    rep_d     = rep_q;
    mode_d    = mode_q;
    load_data = 1'b0;
    if (UPDATE) begin
      if (!req_valid) begin
        err_d = 1'b1;
      end else begin
        err_d     = 1'b0;
        stop_d    = 1'b0;
        req_seg_d = REQ_SEGMENT;
        rep_d     = REQ_REP;
        mode_d    = req_mode;
        cnt_d     = '0;
        if (req_inf) begin
          state_d = ST_IDLE;
          seg_d   = REQ_SEGMENT;
          swap_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          state_d   = ST_PENDING;
          busy_d    = 1'b1;
          load_data = 1'b1;
        end
      end
    end else begin
      case (state_q)
        ST_PENDING: begin
          if (trig) begin
            seg_d   = req_seg_q;
            swap_d  = 1'b1;
            busy_d  = 1'b0;
            cnt_d   = '0;
            state_d = ST_COUNT;
          end
        end
        ST_COUNT: begin
          // A loop end coincident with the swap belongs to the old segment.
          if (LOOP_END && !swap_q) begin
            if (cnt_q == rep_q) begin
              if (mode_q == ModeExt) begin
                seg_d  = seg_adv;
                swap_d = 1'b1;
                cnt_d  = '0;
              end else begin
                stop_d  = 1'b1;
                state_d = ST_STOPPED;
              end
            end else begin
              cnt_d = cnt_q + RepWidth'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Control registers; reset returns to IDLE with an infinite repeat.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= ST_IDLE;
      seg_q       <= '0;
      swap_q      <= 1'b0;
      stop_q      <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
      req_seg_q   <= '0;
      rep_q       <= '1;
      mode_q      <= ModeSync;
      gpio_prev_q <= '0;
    end else begin
      state_q     <= state_d;
      seg_q       <= seg_d;
      swap_q      <= swap_d;
      stop_q      <= stop_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
      req_seg_q   <= req_seg_d;
      rep_q       <= rep_d;
      mode_q      <= mode_d;
      gpio_prev_q <= GPIO_IN;
    end
  end

  // Trigger operands of a finite request; read only while PENDING.
  always_ff @(posedge CLK) begin
    if (load_data) begin
      target_q <= TRANSITION_VALUE[SysTimeWidth-1:0];
      pin_q    <= TRANSITION_VALUE[PinWidth-1:0];
    end
  end

  // Outputs come straight from registers.
  always_comb begin
    SEGMENT = seg_q;
    SWAP    = swap_q;
    STOP    = stop_q;
    BUSY    = busy_q;
    ERR     = err_q;
  end

endmodule
